// File: rtl/lava_pkg.sv
// Purpose: shared sizes, pixel type and FSM state encoding for the frame buffer.
// Ports: none (package).
package lava_pkg;

  localparam int unsigned PIX_W     = 12;
  localparam int unsigned COLS      = 64;
  localparam int unsigned HALF_ROWS = 16;
  localparam int unsigned HALF_PIX  = COLS * HALF_ROWS;
  localparam int unsigned RD_AW     = $clog2(HALF_PIX);
  localparam int unsigned WR_AW     = RD_AW + 1;

  // RGB444 {r[3:0], g[3:0], b[3:0]}
  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_PEND = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_bram.sv
// Purpose: simple dual-port RAM, one write port and one registered read port
//          (1-cycle read latency). Only the read register is reset.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (read register only)
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  registered read data
module fb_bram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Storage write; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/frame_buf.sv
// Purpose: double-buffered 64x32 RGB444 pixel store. The renderer fills the
//          back bank while the display scans the front bank; banks swap only
//          on a display frame wrap (r_addr 1023 -> 0).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_en/addr/data  back-bank pixel write {half,row,col}; dropped while busy
//   clear_req        fill back bank with CLEAR_VAL
//   swap_req         swap banks at the next frame wrap
//   busy             clear or swap pending
//   swap_done        high in the cycle the banks swap
//   r_addr           display scan address {row,col}
//   din_top/din_btm  front-bank top/bottom pixels, 1-cycle latency
module frame_buf
  import lava_pkg::*;
#(
  parameter pixel_t CLEAR_VAL = 12'h000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WR_AW-1:0] wr_addr,
  input  pixel_t           wr_data,
  input  logic             clear_req,
  input  logic             swap_req,
  output logic             busy,
  output logic             swap_done,
  input  logic [RD_AW-1:0] r_addr,
  output pixel_t           din_top,
  output pixel_t           din_btm
);

  fb_state_t        r_state;
  fb_state_t        w_state_nxt;
  logic [WR_AW-1:0] r_clr_cnt;
  logic [WR_AW-1:0] w_clr_cnt_nxt;
  logic             r_front;
  logic             w_front_nxt;
  logic             r_rd_bank;
  logic [RD_AW-1:0] r_prev_raddr;
  logic             w_wrap;
  logic             w_we;
  logic [WR_AW-1:0] w_waddr;
  pixel_t           w_wdata;
  pixel_t           w_rdata [2][2];

  // Frame boundary: scan just left the last pixel and restarted at 0.
  assign w_wrap = (r_prev_raddr == '1) && (r_addr == '0);
  assign busy   = (r_state != IDLE);

  // Next-state, back-bank write port and swap control.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_front_nxt   = r_front;
    swap_done     = 1'b0;
    w_we          = 1'b0;
    w_waddr       = wr_addr;
    w_wdata       = wr_data;

    case (r_state)
      IDLE: begin
        w_we = wr_en;
        // Clear has priority; a simultaneous swap request is dropped.
        if (clear_req) begin
          w_state_nxt   = CLEAR;
          w_clr_cnt_nxt = '0;
        end else if (swap_req) begin
          w_state_nxt = SWAP_PEND;
        end
      end
      CLEAR: begin
        w_we          = 1'b1;
        w_waddr       = r_clr_cnt;
        w_wdata       = CLEAR_VAL;
        w_clr_cnt_nxt = r_clr_cnt + WR_AW'(1);
        if (r_clr_cnt == '1) begin
          w_state_nxt = IDLE;
        end
      end
      SWAP_PEND: begin
        if (w_wrap) begin
          w_front_nxt = ~r_front;
          swap_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_clr_cnt    <= '0;
      r_front      <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_prev_raddr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_front      <= w_front_nxt;
      // Read select follows the post-swap front so the wrap-cycle read of
      // address 0 already comes from the new front bank.
      r_rd_bank    <= w_front_nxt;
      r_prev_raddr <= r_addr;
    end
  end

  // Four RAMs: bank b, half h (0 = top, 1 = bottom).
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      logic w_ram_we;
      assign w_ram_we = w_we && (1'(b) != r_front) && (w_waddr[WR_AW-1] == 1'(h));

      fb_bram #(
        .AW (RD_AW),
        .DW (PIX_W)
      ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_ram_we),
        .i_waddr (w_waddr[RD_AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata[b][h])
      );
    end
  end

  assign din_top = w_rdata[r_rd_bank][0];
  assign din_btm = w_rdata[r_rd_bank][1];

endmodule

// File: tb/tb_frame_buf.sv
// Purpose: self-checking bench for frame_buf. A behavioural model tracks bank
//          contents, the front bank and the request FSM; expected read data is
//          queued when r_addr is driven and compared one cycle later.
// Ports: none (top-level bench).
module tb_frame_buf;
  import lava_pkg::*;

  localparam pixel_t CLR = 12'h111;
  localparam int S_IDLE = 0;
  localparam int S_CLR  = 1;
  localparam int S_PEND = 2;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [10:0] wr_addr;
  pixel_t      wr_data;
  logic        clear_req;
  logic        swap_req;
  logic        busy;
  logic        swap_done;
  logic [9:0]  r_addr;
  pixel_t      din_top;
  pixel_t      din_btm;

  frame_buf #(.CLEAR_VAL(CLR)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_req (clear_req),
    .swap_req  (swap_req),
    .busy      (busy),
    .swap_done (swap_done),
    .r_addr    (r_addr),
    .din_top   (din_top),
    .din_btm   (din_btm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    pixel_t top;
    pixel_t btm;
    bit     top_ok;
    bit     btm_ok;
    int     addr;
  } exp_t;

  exp_t   exp_q[$];
  pixel_t m_mem   [2][2][1024];
  bit     m_known [2][2][1024];
  bit     m_front;
  int     m_state;
  int     m_cnt;
  int     m_prev;

  int     n_checks;
  int     n_fail;
  int     sd_pulses;
  int     busy_cycles;
  logic [9:0] ra_ctr;
  pixel_t last_top;
  pixel_t last_btm;

  // One clock: drive inputs, check comb outputs, advance model, check reads.
  task automatic step(input logic [9:0] ra, input logic we, input logic [10:0] wa,
                      input pixel_t wd, input logic clr, input logic swp);
    bit   wrap;
    logic exp_sd;
    logic exp_busy;
    int   bk;
    exp_t e;
    r_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
    clear_req = clr; swap_req = swp;
    #1;
    wrap     = (m_prev == 1023) && (ra == 10'd0);
    exp_busy = (m_state != S_IDLE);
    exp_sd   = (m_state == S_PEND) && wrap;
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy ra=%0d got=%b exp=%b", ra, busy, exp_busy);
    end
    n_checks++;
    if (swap_done !== exp_sd) begin
      n_fail++;
      $display("FAIL swap_done ra=%0d got=%b exp=%b", ra, swap_done, exp_sd);
    end
    if (swap_done === 1'b1) sd_pulses++;
    if (busy === 1'b1) busy_cycles++;
    bk = m_front ? 0 : 1;
    case (m_state)
      S_IDLE: begin
        if (we) begin
          m_mem[bk][int'(wa[10])][int'(wa[9:0])]   = wd;
          m_known[bk][int'(wa[10])][int'(wa[9:0])] = 1'b1;
        end
        if (clr) begin
          m_state = S_CLR;
          m_cnt   = 0;
        end else if (swp) begin
          m_state = S_PEND;
        end
      end
      S_CLR: begin
        m_mem[bk][m_cnt / 1024][m_cnt % 1024]   = CLR;
        m_known[bk][m_cnt / 1024][m_cnt % 1024] = 1'b1;
        if (m_cnt == 2047) m_state = S_IDLE;
        m_cnt++;
      end
      default: begin
        if (wrap) begin
          m_front = ~m_front;
          m_state = S_IDLE;
        end
      end
    endcase
    m_prev   = int'(ra);
    e.addr   = int'(ra);
    e.top    = m_mem[int'(m_front)][0][int'(ra)];
    e.btm    = m_mem[int'(m_front)][1][int'(ra)];
    e.top_ok = m_known[int'(m_front)][0][int'(ra)];
    e.btm_ok = m_known[int'(m_front)][1][int'(ra)];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    last_top = din_top;
    last_btm = din_btm;
    if (e.top_ok) begin
      n_checks++;
      if (din_top !== e.top) begin
        n_fail++;
        $display("FAIL din_top addr=%0d got=%h exp=%h", e.addr, din_top, e.top);
      end
    end
    if (e.btm_ok) begin
      n_checks++;
      if (din_btm !== e.btm) begin
        n_fail++;
        $display("FAIL din_btm addr=%0d got=%h exp=%h", e.addr, din_btm, e.btm);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(ra_ctr, 1'b0, 11'd0, 12'h000, 1'b0, 1'b0);
      ra_ctr = ra_ctr + 10'd1;
    end
  endtask

  task automatic goto_addr(input logic [9:0] a);
    while (ra_ctr != a) idle(1);
  endtask

  task automatic pulse(input logic we, input logic [10:0] wa, input pixel_t wd,
                       input logic clr, input logic swp);
    step(ra_ctr, we, wa, wd, clr, swp);
    ra_ctr = ra_ctr + 10'd1;
  endtask

  // Run until the model says the pending swap has happened (bounded).
  task automatic wait_swap();
    int guard;
    guard = 0;
    while (m_state == S_PEND && guard < 3000) begin
      idle(1);
      guard++;
    end
    n_checks++;
    if (m_state == S_PEND) begin
      n_fail++;
      $display("FAIL wait_swap timeout got=pending exp=swapped");
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    wr_en = 1'b0; clear_req = 1'b0; swap_req = 1'b0;
    // A write may or may not land at the reset edge mid-clear.
    if (m_state == S_CLR) m_known[m_front ? 0 : 1][m_cnt / 1024][m_cnt % 1024] = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    m_state = S_IDLE; m_front = 1'b0; m_prev = int'(r_addr); m_cnt = 0;
    // prev_raddr resets to 0 rather than tracking r_addr during reset
    m_prev = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    r_addr = 10'd0; wr_addr = 11'd0; wr_data = 12'h000;
    do_reset(3);
    n_checks++;
    if (din_top !== 12'h000) begin n_fail++; $display("FAIL reset_din_top got=%h exp=000", din_top); end
    n_checks++;
    if (din_btm !== 12'h000) begin n_fail++; $display("FAIL reset_din_btm got=%h exp=000", din_btm); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (swap_done !== 1'b0) begin n_fail++; $display("FAIL reset_swap_done got=%b exp=0", swap_done); end
    n_checks++;
    if (dut.r_front !== 1'b0) begin n_fail++; $display("FAIL reset_front got=%b exp=0", dut.r_front); end
  endtask

  // Fill both banks with known contents so every later read is checkable.
  task automatic init_banks();
    pulse(1'b0, 11'd0, 12'h000, 1'b1, 1'b0);
    idle(2050);
    pulse(1'b0, 11'd0, 12'h000, 1'b0, 1'b1);
    wait_swap();
    pulse(1'b0, 11'd0, 12'h000, 1'b1, 1'b0);
    idle(2050);
  endtask

  task automatic test_top_write();
    pulse(1'b1, 11'd197, 12'hABC, 1'b0, 1'b0);
    goto_addr(10'd1);
    sd_pulses = 0;
    pulse(1'b0, 11'd0, 12'h000, 1'b0, 1'b1);
    goto_addr(10'd197);
    idle(1);
    n_checks++;
    if (last_top !== CLR) begin n_fail++; $display("FAIL top197_old got=%h exp=%h", last_top, CLR); end
    wait_swap();
    n_checks++;
    if (sd_pulses != 1) begin n_fail++; $display("FAIL top_swap_pulses got=%0d exp=1", sd_pulses); end
    goto_addr(10'd197);
    idle(1);
    n_checks++;
    if (last_top !== 12'hABC) begin n_fail++; $display("FAIL top197_new got=%h exp=abc", last_top); end
  endtask

  task automatic test_btm_write();
    pulse(1'b1, 11'd1031, 12'h5A5, 1'b0, 1'b0);
    goto_addr(10'd1);
    pulse(1'b0, 11'd0, 12'h000, 1'b0, 1'b1);
    goto_addr(10'd7);
    idle(1);
    n_checks++;
    if (last_btm !== CLR) begin n_fail++; $display("FAIL btm7_old got=%h exp=%h", last_btm, CLR); end
    wait_swap();
    goto_addr(10'd7);
    idle(1);
    n_checks++;
    if (last_btm !== 12'h5A5) begin n_fail++; $display("FAIL btm7_new got=%h exp=5a5", last_btm); end
    n_checks++;
    if (last_top !== CLR) begin n_fail++; $display("FAIL top7_kept got=%h exp=%h", last_top, CLR); end
  endtask

  task automatic test_clear();
    int bad;
    busy_cycles = 0;
    pulse(1'b0, 11'd0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 2050; i++) begin
      if (i % 256 == 5) pulse(1'b1, 11'(i % 2048), 12'hFFF, 1'b0, 1'b0);
      else if (i == 100) pulse(1'b1, 11'd197, 12'hFFF, 1'b0, 1'b0);
      else idle(1);
    end
    n_checks++;
    if (busy_cycles != 2048) begin n_fail++; $display("FAIL clear_busy_len got=%0d exp=2048", busy_cycles); end
    goto_addr(10'd1);
    pulse(1'b0, 11'd0, 12'h000, 1'b0, 1'b1);
    wait_swap();
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      idle(1);
      if (last_top !== CLR || last_btm !== CLR) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL clear_readback got=%0d_bad exp=0_bad", bad); end
  endtask

  task automatic test_swap_wrap();
    bit f_saved;
    sd_pulses = 0;
    step(10'd960, 1'b0, 11'd0, 12'h000, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int a = 960; a < 1024; a++) step(10'(a), 1'b0, 11'd0, 12'h000, 1'b0, 1'b0);
    end
    n_checks++;
    if (sd_pulses != 0) begin n_fail++; $display("FAIL repeat_no_swap got=%0d exp=0", sd_pulses); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL repeat_busy got=%b exp=1", busy); end
    step(10'd0, 1'b0, 11'd0, 12'h000, 1'b0, 1'b0);
    n_checks++;
    if (sd_pulses != 1) begin n_fail++; $display("FAIL wrap_swap got=%0d exp=1", sd_pulses); end
    ra_ctr = 10'd1;
    idle(20);
    n_checks++;
    if (sd_pulses != 1) begin n_fail++; $display("FAIL wrap_swap_once got=%0d exp=1", sd_pulses); end
    // Simultaneous clear and swap: clear wins, swap is lost.
    sd_pulses = 0;
    f_saved = m_front;
    busy_cycles = 0;
    pulse(1'b0, 11'd0, 12'h000, 1'b1, 1'b1);
    idle(2050 + 1100);
    n_checks++;
    if (busy_cycles != 2048) begin n_fail++; $display("FAIL clr_swap_busy got=%0d exp=2048", busy_cycles); end
    n_checks++;
    if (sd_pulses != 0) begin n_fail++; $display("FAIL clr_swap_dropped got=%0d exp=0", sd_pulses); end
    n_checks++;
    if (dut.r_front !== f_saved) begin n_fail++; $display("FAIL clr_swap_front got=%b exp=%b", dut.r_front, f_saved); end
  endtask

  task automatic test_reset_mid_clear();
    pulse(1'b0, 11'd0, 12'h000, 1'b1, 1'b0);
    idle(1000);
    n_checks++;
    if (dut.r_clr_cnt !== 11'd1000) begin n_fail++; $display("FAIL clr_cnt got=%0d exp=1000", dut.r_clr_cnt); end
    do_reset(1);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy got=%b exp=0", busy); end
    n_checks++;
    if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL midclr_state got=%0d exp=%0d", dut.r_state, IDLE); end
    n_checks++;
    if (dut.r_front !== 1'b0) begin n_fail++; $display("FAIL midclr_front got=%b exp=0", dut.r_front); end
    busy_cycles = 0;
    pulse(1'b0, 11'd0, 12'h000, 1'b1, 1'b0);
    idle(2050);
    n_checks++;
    if (busy_cycles != 2048) begin n_fail++; $display("FAIL reclear_busy got=%0d exp=2048", busy_cycles); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; sd_pulses = 0; busy_cycles = 0;
    m_front = 1'b0; m_state = S_IDLE; m_cnt = 0; m_prev = 0;
    ra_ctr = 10'd0;
    rst = 1'b1; wr_en = 1'b0; clear_req = 1'b0; swap_req = 1'b0;
    wr_addr = 11'd0; wr_data = 12'h000; r_addr = 10'd0;
    test_reset();
    init_banks();
    test_top_write();
    test_btm_write();
    test_clear();
    test_swap_wrap();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
